// File: rtl/mem_access_sequencer.sv
// Arbitrates the shared rv32 memory bus between instruction fetch and data load/store.
// Optional wait-state timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_sel,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic [31:0] dmem_rdata,
    output logic        data_valid,
    output logic        stall,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t      state, state_next;
    logic        data_done;
    logic [1:0]  lane_q;
    logic        is_byte_q;
    logic        is_write_q;
    logic        issue_data, issue_fetch;
    logic        timeout;
    logic        data_req;
    logic        bus_ready;
    logic [7:0]  load_lane;

    assign data_req  = (dmem_read | dmem_write) & ~data_done;
    assign bus_ready = (state != IDLE) & ~bus_busy;
    assign load_lane = bus_rdata[{lane_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_next;
    end

    // Data wins over fetch so the current instruction's access finishes before the next fetch.
    always_comb begin
        state_next  = state;
        issue_data  = 1'b0;
        issue_fetch = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    state_next = DATA;
                    issue_data = 1'b1;
                end else if (fetch_req) begin
                    state_next  = FETCH;
                    issue_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (timeout || !bus_busy) state_next = IDLE;
            end
            DATA: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (!bus_busy) begin
                    if (fetch_req) begin
                        state_next  = FETCH;
                        issue_fetch = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            bus_sel     <= '0;
            instruction <= '0;
            inst_valid  <= 1'b0;
            dmem_rdata  <= '0;
            data_valid  <= 1'b0;
            stall       <= 1'b0;
            data_done   <= 1'b0;
            lane_q      <= '0;
            is_byte_q   <= 1'b0;
            is_write_q  <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            stall      <= (state_next != IDLE);

            // A simultaneous read and write request is treated as a write.
            if (issue_data) begin
                bus_addr   <= {dmem_addr[31:2], 2'b00};
                lane_q     <= dmem_addr[1:0];
                is_write_q <= dmem_write;
                is_byte_q  <= dmem_write ? store_byte : load_byte;
                bus_write  <= dmem_write;
                bus_read   <= ~dmem_write;
                if (dmem_write ? store_byte : load_byte) bus_sel <= 4'b0001 << dmem_addr[1:0];
                else                                     bus_sel <= 4'b1111;
                if (!dmem_write)     bus_wdata <= '0;
                else if (store_byte) bus_wdata <= {4{dmem_wdata[7:0]}};
                else                 bus_wdata <= dmem_wdata;
            end else if (issue_fetch) begin
                bus_addr   <= {fetch_addr[31:2], 2'b00};
                lane_q     <= fetch_addr[1:0];
                is_write_q <= 1'b0;
                is_byte_q  <= 1'b0;
                bus_read   <= 1'b1;
                bus_write  <= 1'b0;
                bus_sel    <= 4'b1111;
                bus_wdata  <= '0;
            end else if (state_next == IDLE) begin
                bus_read  <= 1'b0;
                bus_write <= 1'b0;
            end

            if (state == FETCH && bus_ready) begin
                instruction <= bus_rdata;
                inst_valid  <= 1'b1;
                data_done   <= 1'b0;
            end

            // data_done keeps a still-held decoder request from re-issuing until the next fetch lands.
            if (state == DATA && bus_ready) begin
                data_valid <= 1'b1;
                data_done  <= 1'b1;
                if (!is_write_q) begin
                    if (is_byte_q) dmem_rdata <= {{24{load_lane[7]}}, load_lane};
                    else           dmem_rdata <= bus_rdata;
                end
            end

            if (state == DATA && timeout) data_done <= 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] busy_cnt;

    assign timeout = (state != IDLE) && bus_busy && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            busy_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            bus_error <= timeout;
            if (issue_data || issue_fetch)      busy_cnt <= '0;
            else if (state != IDLE && bus_busy) busy_cnt <= busy_cnt + 1'b1;
        end
    end
`else
    wire unused_params = ^{32'(TIMEOUT_CYCLES), 32'(CNT_W)};

    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

endmodule
